// File: rtl/window_fetch_ctrl.sv
// 3x3 window fetch controller: walks every interior centre pixel, issues nine reads per
// window into the external shift register, then offers the window to the Sobel stage.
module window_fetch_ctrl #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [PIX_W-1:0]  i_mem_rdata,
  input  logic              i_mem_rvalid,
  output logic [PIX_W-1:0]  o_pix_out,
  output logic              o_shift_enable,
  output logic              o_clear,
  output logic              o_window_valid,
  input  logic              i_window_ack,
  output logic [15:0]       o_ctr_row,
  output logic [15:0]       o_ctr_col,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_REQ, S_WAIT, S_SETTLE, S_PRESENT, S_NEXT, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] WRAP_A   = ADDR_W'(3);
  localparam logic [15:0]       LAST_COL = 16'(IMG_W - 2);
  localparam logic [15:0]       LAST_ROW = 16'(IMG_H - 2);

  state_t            r_state;
  logic [15:0]       r_row, r_col;
  logic [3:0]        r_k;
  logic [1:0]        r_dc;
  logic [ADDR_W-1:0] r_wbase, r_tap;

  logic              w_last_col;
  logic [ADDR_W-1:0] w_next_wbase, w_next_tap;

  // Window base is the top-left tap; moving off the last column lands three pixels
  // further on, at column 0 of the next row.
  assign w_last_col   = (r_col == LAST_COL);
  assign w_next_wbase = r_wbase + (w_last_col ? WRAP_A : ONE_A);
  assign w_next_tap   = r_tap + ((r_dc == 2'd2) ? ROW_STEP : ONE_A);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state        <= S_IDLE;
      r_row          <= '0;
      r_col          <= '0;
      r_k            <= '0;
      r_dc           <= '0;
      r_wbase        <= '0;
      r_tap          <= '0;
      o_mem_rd       <= 1'b0;
      o_mem_addr     <= '0;
      o_pix_out      <= '0;
      o_shift_enable <= 1'b0;
      o_clear        <= 1'b0;
      o_window_valid <= 1'b0;
      o_ctr_row      <= '0;
      o_ctr_col      <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      o_shift_enable <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_wbase <= i_base_addr;
          r_tap   <= i_base_addr;
          r_row   <= 16'd1;
          r_col   <= 16'd1;
          r_k     <= '0;
          r_dc    <= '0;
          o_clear <= 1'b1;
          o_busy  <= 1'b1;
          r_state <= S_CLR;
        end
        S_CLR: begin
          o_clear    <= 1'b0;
          o_mem_rd   <= 1'b1;
          o_mem_addr <= r_tap;
          r_state    <= S_REQ;
        end
        S_REQ: begin
          o_mem_rd <= 1'b0;
          r_state  <= S_WAIT;
        end
        S_WAIT: if (i_mem_rvalid) begin
          o_pix_out      <= i_mem_rdata;
          o_shift_enable <= 1'b1;
          if (r_k == 4'd8) begin
            r_k     <= '0;
            r_dc    <= '0;
            r_state <= S_SETTLE;
          end else begin
            r_k        <= r_k + 4'd1;
            r_dc       <= (r_dc == 2'd2) ? 2'd0 : r_dc + 2'd1;
            r_tap      <= w_next_tap;
            o_mem_rd   <= 1'b1;
            o_mem_addr <= w_next_tap;
            r_state    <= S_REQ;
          end
        end
        S_SETTLE: begin
          o_window_valid <= 1'b1;
          o_ctr_row      <= r_row;
          o_ctr_col      <= r_col;
          r_state        <= S_PRESENT;
        end
        S_PRESENT: if (i_window_ack) begin
          o_window_valid <= 1'b0;
          r_state        <= S_NEXT;
        end
        S_NEXT: begin
          if (w_last_col) begin
            r_col <= 16'd1;
            r_row <= r_row + 16'd1;
          end else begin
            r_col <= r_col + 16'd1;
          end
          r_wbase <= w_next_wbase;
          r_tap   <= w_next_wbase;
          if (w_last_col && r_row == LAST_ROW) begin
            o_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            o_mem_rd   <= 1'b1;
            o_mem_addr <= w_next_wbase;
            r_state    <= S_REQ;
          end
        end
        S_DONE: begin
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
